// File: rtl/mux_arb_reg.sv
// mux_arb_reg
// Registered N-way selector with per-channel valid/ready handshakes.
// In fixed mode the channel named by 'select' is granted. In round-robin
// mode the first valid channel at or after the rotating pointer is granted.
// The granted word goes into a single-entry output register that supports
// backpressure (out_ready) and flush.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   mode       0 = fixed select, 1 = round-robin
//   select     channel index used in fixed mode
//   flush      drop the held output word, block acceptance this cycle
//   out_data   registered selected word
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts out_data
module mux_arb_reg #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] grant_sel;
    logic             grant_vld;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // Grant selection. Fixed mode grants 'select' whenever it names an
    // existing channel, whether or not that channel is valid. Round-robin
    // does two passes: first over channels at or above the pointer, then
    // over all channels from 0. The second pass is the wrap-around.
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = '0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (select == SEL_W'(i)) begin
                    grant_vld = 1'b1;
                    grant_sel = SEL_W'(i);
                end
            end
        end else begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!grant_vld && in_valid[i] &&
                        (pass == 1 || SEL_W'(i) >= ptr)) begin
                        grant_vld = 1'b1;
                        grant_sel = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Handshake side. The register can take a word when it is empty, or
    // when its current word leaves on this same edge. Reset and flush
    // block acceptance. Only the granted channel sees ready.
    always_comb begin
        can_accept = !rst && !flush && (!out_valid || out_ready);
        in_ready   = '0;
        grant_data = '0;
        ptr_nxt    = ptr;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_vld && grant_sel == SEL_W'(i)) begin
                in_ready[i] = can_accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
                ptr_nxt     = (i == NUM_IN - 1) ? '0 : SEL_W'(i + 1);
            end
        end
        xfer = |(in_ready & in_valid);
    end

    // Output register and round-robin pointer. A new transfer takes
    // priority: it overwrites the register even when the old word is
    // leaving on the same edge, which keeps throughput at one word per
    // cycle. Without a transfer, a downstream handshake or a flush empties
    // the register. Clearing out_valid when it is already 0 is harmless.
    // data/sel keep their values in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant_sel;
            if (mode) begin
                ptr <= ptr_nxt;
            end
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg
// Scoreboard bench for mux_arb_reg. The stimulus task drives one cycle of
// inputs and runs a behavioural reference model. When the model predicts a
// transfer, it pushes the expected {data, sel} into a queue. A separate
// monitor compares out_valid with the queue occupancy on every cycle, and
// pops and compares the word on every downstream handshake. A second,
// 3-channel instance covers select values that name no channel.
module tb_mux_arb_reg;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_IN*WIDTH-1:0] in_data = '0;
    logic [NUM_IN-1:0]       in_valid = '0;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode = 1'b0;
    logic [SEL_W-1:0]        select = '0;
    logic                    flush = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    // Signals for the 3-channel instance
    logic [3*WIDTH-1:0]      in_data3 = '0;
    logic [2:0]              in_valid3 = '0;
    logic [2:0]              in_ready3;
    logic [SEL_W-1:0]        select3 = '0;
    logic [WIDTH-1:0]        out_data3;
    logic [SEL_W-1:0]        out_sel3;
    logic                    out_valid3;
    logic                    out_ready3 = 1'b0;

    int checks = 0;
    int errors = 0;
    bit dut3_done = 1'b0;

    // Reference model state: queue of words the output register should
    // hold, plus the round-robin pointer
    logic [WIDTH+SEL_W-1:0] exp_q[$];
    int                     ptr_m = 0;

    mux_arb_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .select(select), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_arb_reg #(.WIDTH(WIDTH), .NUM_IN(3), .SEL_W(SEL_W)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(1'b0), .select(select3), .flush(1'b0),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: returns the granted channel, or -1 if none
    function automatic int model_grant(input bit m, input int sel,
                                       input logic [NUM_IN-1:0] v, input int p);
        if (!m) return (sel < NUM_IN) ? sel : -1;
        for (int k = 0; k < NUM_IN; k++) begin
            int idx;
            idx = (p + k) % NUM_IN;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Drives one cycle of inputs, checks in_ready against the model, then
    // updates the model to match what the coming rising edge should do
    task automatic applyStimulus(input bit r, input bit m, input int sel,
                                 input logic [NUM_IN-1:0] v,
                                 input logic [NUM_IN*WIDTH-1:0] d,
                                 input bit fl, input bit ordy);
        int g;
        bit accept, xfer_m;
        logic [NUM_IN-1:0] rdy_m;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        rst = r; mode = m; select = SEL_W'(sel); in_valid = v;
        in_data = d; flush = fl; out_ready = ordy;
        if (r) begin
            exp_q.delete();
            ptr_m = 0;
        end
        #1;
        g = model_grant(m, sel, v, ptr_m);
        accept = !r && !fl && (exp_q.size() == 0 || ordy);
        rdy_m = '0;
        if (g >= 0 && accept) rdy_m[g] = 1'b1;
        xfer_m = (g >= 0) && accept && v[g];
        checkOutput("in_ready", 32'(in_ready), 32'(rdy_m));
        if (r) begin
            checkOutput("rst_out_data", 32'(out_data), 0);
            checkOutput("rst_out_sel", 32'(out_sel), 0);
        end
        #2;
        // The monitor has popped any handshaked word by now. A flush drops
        // whatever is still held.
        if (fl) exp_q.delete();
        if (xfer_m) begin
            w = d[g*WIDTH +: WIDTH];
            exp_q.push_back({w, SEL_W'(g)});
            if (m) ptr_m = (g + 1) % NUM_IN;
        end
    endtask

    // Monitor: checks occupancy every cycle and the word on each handshake
    initial begin
        logic [WIDTH+SEL_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && out_ready && !flush && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(e[WIDTH+SEL_W-1:SEL_W]));
                checkOutput("out_sel", 32'(out_sel), 32'(e[SEL_W-1:0]));
            end
        end
    end

    // 3-channel instance: a select of 3 names no channel, then select 2 works
    initial begin
        repeat (3) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
            in_data3 = {5'd21, 5'd22, 5'd23};
            #1;
            checkOutput("oor_in_ready", 32'(in_ready3), 0);
            checkOutput("oor_out_valid", 32'(out_valid3), 0);
        end
        @(negedge clk);
        select3 = 2'd2;
        #1;
        checkOutput("n3_in_ready", 32'(in_ready3), 32'(3'b100));
        @(negedge clk);
        in_valid3 = 3'b000;
        #1;
        checkOutput("n3_out_valid", 32'(out_valid3), 1);
        checkOutput("n3_out_data", 32'(out_data3), 21);
        checkOutput("n3_out_sel", 32'(out_sel3), 2);
        dut3_done = 1'b1;
    end

    initial begin
        logic [NUM_IN*WIDTH-1:0] rr_data;
        rr_data = {5'd13, 5'd12, 5'd11, 5'd10};

        // Reset held for two cycles
        applyStimulus(1, 0, 2, 4'b1111, '0, 0, 1);
        applyStimulus(1, 0, 2, 4'b1111, '0, 0, 1);

        // Backpressure: load 7 from ch1, stall 3 cycles, then consume 7
        // and load 20 on the same edge
        applyStimulus(0, 0, 1, 4'b0010, 20'(5'd7) << WIDTH, 0, 0);
        for (int c = 0; c < 3; c++)
            applyStimulus(0, 0, 1, 4'b0010, 20'(5'd20) << WIDTH, 0, 0);
        applyStimulus(0, 0, 1, 4'b0010, 20'(5'd20) << WIDTH, 0, 1);
        applyStimulus(0, 0, 1, 4'b0000, '0, 0, 1);

        // Round-robin fairness from ptr 0. Seven grants 0,1,2,3,0,1,2
        // leave ptr at 3.
        for (int c = 0; c < 7; c++)
            applyStimulus(0, 1, 0, 4'b1111, rr_data, 0, 1);

        // Skip and wrap: grants 0, 2, 0
        for (int c = 0; c < 3; c++)
            applyStimulus(0, 1, 0, 4'b0101, rr_data, 0, 1);
        applyStimulus(0, 1, 0, 4'b0000, rr_data, 0, 1);

        // Flush while holding 9 with out_ready high
        applyStimulus(0, 0, 0, 4'b0001, 20'(5'd9), 0, 0);
        applyStimulus(0, 1, 0, 4'b0001, 20'(5'd4), 1, 1);
        #3;
        checkOutput("flush_out_valid", 32'(out_valid), 0);
        checkOutput("flush_out_data", 32'(out_data), 9);
        applyStimulus(0, 1, 0, 4'b0001, 20'(5'd4), 0, 1);
        applyStimulus(0, 1, 0, 4'b0000, '0, 0, 1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            applyStimulus(0, 1'($urandom), int'($urandom_range(0, NUM_IN - 1)),
                          4'($urandom), 20'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0));
        end

        // Reset mid-run, then the fixed path from ch2
        applyStimulus(1, 0, 2, 4'b0100, 20'(5'd31) << (2*WIDTH), 0, 1);
        applyStimulus(0, 0, 2, 4'b0100, 20'(5'd31) << (2*WIDTH), 0, 1);
        applyStimulus(0, 0, 2, 4'b0000, '0, 0, 1);
        // After reset the pointer is 0, so round-robin grants ch0 first
        applyStimulus(0, 1, 0, 4'b1111, rr_data, 0, 1);
        for (int c = 0; c < 3; c++)
            applyStimulus(0, 1, 0, 4'b0000, '0, 0, 1);

        checkOutput("dut3_done", 32'(dut3_done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
